// File: rtl/yuv_pack_pkg.sv
// Shared types and helpers for the YUV332 packing path.
package yuv_pack_pkg;

  localparam int PIXELS_PER_WORD = 4;
  localparam int WORD_W          = 32;

  typedef logic [PIXELS_PER_WORD-1:0] keep_t;

  // One FIFO entry: packed word, byte-valid mask and end-of-frame tag.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    keep_t             keep;
    logic              last;
  } fifo_word_t;

  localparam int FIFO_W = $bits(fifo_word_t);

  // Prefix mask for a byte count: 0 -> 0000, 2 -> 1100, 4 -> 1111.
  function automatic keep_t keep_mask(input logic [2:0] count);
    keep_t mask;
    case (count)
      3'd0:    mask = 4'b0000;
      3'd1:    mask = 4'b1000;
      3'd2:    mask = 4'b1100;
      3'd3:    mask = 4'b1110;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with (log2(DEPTH)+1)-bit pointers.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and pushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Store accepted words.
  // NOTE: storage is not reset; pointers define validity, and the head is gated off while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/yuv332_packer.sv
// Packs YUV332 bytes four-per-word (first pixel in [31:24]), flushes partial
// words on frame end and queues results in a FWFT FIFO towards the consumer.
module yuv332_packer
  import yuv_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        yuv332,
  input  logic              wr_en_i,
  input  logic              frame_start_i,
  input  logic              frame_end_i,
  output logic [WORD_W-1:0] data_o,
  output keep_t             keep_o,
  output logic              last_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overflow_o
);

  // Assembly register: lanes 0..2 (lane 0 in [23:16]) plus the next lane index.
  logic [23:0] r_asm;
  logic [1:0]  r_idx;
  logic        r_overflow;

  logic        w_restart;
  logic [1:0]  w_lane;
  logic [31:0] w_word;
  logic [2:0]  w_count;
  logic        w_push;
  fifo_word_t  w_push_word;
  logic [FIFO_W-1:0] w_rdata;
  fifo_word_t  w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_drop;

  // Merge the incoming byte into the assembly and decide whether a word leaves.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_restart = frame_start_i && !frame_end_i;
    w_lane    = w_restart ? 2'd0 : r_idx;
    w_word    = {(w_restart ? 24'h0 : r_asm), 8'h00};
    if (wr_en_i) begin
      case (w_lane)
        2'd0:    w_word[31:24] = yuv332;
        2'd1:    w_word[23:16] = yuv332;
        2'd2:    w_word[15:8]  = yuv332;
        default: w_word[7:0]   = yuv332;
      endcase
    end
    w_count = {1'b0, w_lane} + {2'b00, wr_en_i};
    // A full word always leaves; frame end also flushes partials or emits a terminator.
    w_push  = (w_count == 3'd4) || frame_end_i;
    w_push_word.data = w_word;
    w_push_word.keep = keep_mask(w_count);
    w_push_word.last = frame_end_i;
  end

  // Update assembly lanes and index; lanes at or above the index are kept zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (w_push) begin
      r_asm <= '0;
      r_idx <= '0;
    end else begin
      r_asm <= w_word[31:8];
      r_idx <= w_count[1:0];
    end
  end

  assign w_pop  = valid_o && ready_i;
  assign w_drop = w_push && w_full && !w_pop;

  // Sticky overflow; frame start is processed after frame end, so its clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_overflow <= 1'b0;
    else if (frame_start_i) r_overflow <= 1'b0;
    else if (w_drop)        r_overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty)
  );

  assign w_head     = fifo_word_t'(w_rdata);
  assign valid_o    = !w_empty;
  assign data_o     = valid_o ? w_head.data : '0;
  assign keep_o     = valid_o ? w_head.keep : '0;
  assign last_o     = valid_o ? w_head.last : 1'b0;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_yuv332_packer.sv
// Self-checking bench for yuv332_packer against a queue-based pixel/word model.
module tb_yuv332_packer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic [7:0]  yuv332;
  logic        wr_en_i;
  logic        frame_start_i;
  logic        frame_end_i;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic        overflow_o;

  yuv332_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .yuv332        (yuv332),
    .wr_en_i       (wr_en_i),
    .frame_start_i (frame_start_i),
    .frame_end_i   (frame_end_i),
    .data_o        (data_o),
    .keep_o        (keep_o),
    .last_o        (last_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .overflow_o    (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t       mq[$];
  logic [7:0] pend[$];
  logic       m_ovf;
  int         n_checks;
  int         n_fail;

  // One clock: drive inputs, compare outputs with the model, step the model, move to next negedge.
  task automatic cycle(input logic wr, input logic [7:0] b, input logic fs,
                       input logic fe, input logic rdy);
    exp_t w;
    logic pop;
    logic was_full;
    int   n;
    yuv332 = b; wr_en_i = wr; frame_start_i = fs; frame_end_i = fe; ready_i = rdy;
    #1;
    n_checks++;
    if (valid_o !== (mq.size() > 0)) begin
      n_fail++;
      $display("FAIL valid: got %b expected %b at %0t", valid_o, mq.size() > 0, $time);
    end
    if (mq.size() > 0) begin
      n_checks++;
      if ({data_o, keep_o, last_o} !== {mq[0].d, mq[0].k, mq[0].l}) begin
        n_fail++;
        $display("FAIL head: got %h/%b/%b expected %h/%b/%b at %0t",
                 data_o, keep_o, last_o, mq[0].d, mq[0].k, mq[0].l, $time);
      end
    end
    n_checks++;
    if (overflow_o !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %b expected %b at %0t", overflow_o, m_ovf, $time);
    end
    // Model step.
    pop      = (mq.size() > 0) && rdy;
    was_full = (mq.size() == DEPTH);
    if (fs && !fe) pend.delete();
    if (wr) pend.push_back(b);
    if (pop) void'(mq.pop_front());
    if (pend.size() == 4 || fe) begin
      n   = pend.size();
      w.d = '0;
      for (int i = 0; i < n; i++) w.d[31-8*i -: 8] = pend[i];
      w.k = 4'hF << (4 - n);
      w.l = fe;
      pend.delete();
      if (!was_full || pop) mq.push_back(w);
      else m_ovf = 1'b1;
    end
    if (fs) m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({valid_o, data_o, keep_o, last_o, overflow_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%h/%b/%b/%b expected all zero",
               valid_o, data_o, keep_o, last_o, overflow_o);
    end
    reset_n = 1'b1;
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stream();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b0, i == 8, 1'b1);
      if (i == 4 || i == 8) begin
        n_checks++;
        if ({valid_o, data_o, keep_o, last_o} !==
            {1'b1, (i == 4) ? 32'h01020304 : 32'h05060708, 4'b1111, i == 8}) begin
          n_fail++;
          $display("FAIL stream_word%0d: got %b/%h/%b/%b", i / 4, valid_o, data_o, keep_o, last_o);
        end
      end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_partial();
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({valid_o, data_o, keep_o, last_o} !== {1'b1, 32'hAABB0000, 4'b1100, 1'b1}) begin
      n_fail++;
      $display("FAIL partial: got %b/%h/%b/%b expected 1/aabb0000/1100/1", valid_o, data_o, keep_o, last_o);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_terminator();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({valid_o, data_o, keep_o, last_o} !== {1'b1, 32'h0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL terminator: got %b/%h/%b/%b expected 1/00000000/0000/1", valid_o, data_o, keep_o, last_o);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({valid_o, data_o, overflow_o} !== {1'b1, 32'h20212223, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_hold: got %b/%h/%b expected 1/20212223/1", valid_o, data_o, overflow_o);
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_count: got valid %b expected 0 after 4 pops", valid_o);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b expected 0", overflow_o);
    end
  endtask

  task automatic test_full_pop();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, i == 19);
    n_checks++;
    if ({valid_o, overflow_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_pop: got valid/ovf %b%b expected 10", valid_o, overflow_o);
    end
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_drain: got valid %b expected 0", valid_o);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    wr_en_i = 1'b0; frame_start_i = 1'b0; frame_end_i = 1'b0; ready_i = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, data_o} !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid %b data %h expected 0/00000000", valid_o, data_o);
    end
    mq.delete(); pend.delete(); m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({valid_o, data_o, keep_o} !== {1'b1, 32'h11121314, 4'b1111}) begin
      n_fail++;
      $display("FAIL reset_resume: got %b/%h/%b expected 1/11121314/1111", valid_o, data_o, keep_o);
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 40) == 0,
            ($urandom % 30) == 0, ($urandom % 3) != 0);
    repeat (8) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_ovf = 1'b0;
    reset_n = 1'b0; yuv332 = '0; wr_en_i = 1'b0; frame_start_i = 1'b0;
    frame_end_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_stream();
    test_partial();
    test_terminator();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/yuv332_packer.md
# yuv332_packer

Packs the 8-bit YUV332 pixel stream from the colour-space converter into 32-bit words for the frame-buffer/SPI read-out path. Four consecutive pixels form one word. A small FIFO decouples the pixel-rate producer from a valid/ready consumer. Frame markers align byte lanes, flush partial words and tag the last word of each frame.

## Interface
Parameters:
- FIFO_DEPTH, 4, word capacity of the output FIFO; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock for the block
- reset_n  in  1  asynchronous, active-low reset
- yuv332  in  8  pixel byte, sampled when wr_en_i=1
- wr_en_i  in  1  pixel strobe; one byte per cycle
- frame_start_i  in  1  one-cycle pulse; realigns lanes to lane 0 and clears overflow_o
- frame_end_i  in  1  one-cycle pulse; flushes the assembly register and tags the word as last
- data_o  out  32  packed word; first pixel in [31:24], fourth pixel in [7:0]
- keep_o  out  4  valid-byte mask for data_o; bit 3 corresponds to [31:24]
- last_o  out  1  word closes a frame
- valid_o  out  1  FIFO head is valid
- ready_i  in  1  consumer accepts the head word when valid_o and ready_i are both 1
- overflow_o  out  1  sticky flag: at least one word was dropped because the FIFO was full

## Operation
- Assembly register holds 24 bits of data plus a 2-bit lane index (idx, 0..3).
- On wr_en_i, the byte is written to lane idx and idx increments.
  - When the write fills lane 3, the word is pushed with keep=1111 and last=frame_end_i.
  - idx then returns to 0.
- frame_start_i:
  - Discards any partial assembly and sets idx to 0.
  - Clears overflow_o.
  - A byte strobed in the same cycle lands in lane 0.
  - FIFO contents are not touched.
- frame_end_i:
  - A byte strobed in the same cycle is included first.
  - If bytes are pending after that, the partial word is pushed. Unused lanes are zero, keep is the prefix mask (e.g. 2 bytes gives 1100), and last=1. idx then returns to 0.
  - If nothing is pending and no full word was pushed this cycle, a terminator word is pushed: data=0, keep=0000, last=1.
- frame_start_i and frame_end_i in the same cycle: frame_end_i is processed first, then frame_start_i.
- Push while full:
  - If a pop happens in the same cycle (valid_o and ready_i), the push is accepted.
  - Otherwise the word is dropped and overflow_o is set. Assembly state still advances.
- Output FIFO:
  - First-word fall-through.
  - data_o, keep_o and last_o are valid only while valid_o=1.
  - data_o, keep_o and last_o hold stable while valid_o=1 and ready_i=0.

## Timing
- Reset (asynchronous assert, synchronous release): valid_o=0, data_o=0, keep_o=0, last_o=0, overflow_o=0, FIFO empty, idx=0.
- Latency: a push in cycle N gives valid_o=1 in cycle N+1 if the FIFO was empty.
- Throughput:
  - One pixel per cycle sustained, i.e. one word every 4 cycles.
  - FIFO pop rate of one word per cycle.
- valid_o drops the cycle after the last word is popped, unless a push lands in that same cycle.
- Reset mid-frame discards the assembly register and all FIFO contents. No partial word is emitted.
- Full and empty are derived from log2(FIFO_DEPTH)+1-bit read/write pointers. Wrap-around is by pointer MSB compare.

## Structure
- Package yuv_pack_pkg holds:
  - PIXELS_PER_WORD=4
  - WORD_W=32
  - keep_t (logic [3:0])
  - function keep_mask(idx), returning the prefix mask
- One sub-module: sync_fifo, parameterised by width (32+4+1) and depth.
  - Ports: push/pop/full/empty with first-word fall-through.
  - Reused elsewhere in the read-out path.
- The packer holds only the assembly logic, the flush logic and the overflow flag.

## Test plan
- Continuous stream, ready_i=1: frame_start, then bytes 01..08 on consecutive cycles, then frame_end on the cycle of byte 08.
  - Expect 01020304 / keep 1111 / last 0.
  - Then 05060708 / keep 1111 / last 1.
  - valid_o one cycle after bytes 04 and 08.
- Partial flush: bytes AA, BB, then frame_end alone one cycle later.
  - Expect data AABB0000, keep 1100, last 1.
- Empty terminator: frame_end with idx=0 and no strobe.
  - Expect data 0, keep 0000, last 1.
- Backpressure/overflow, FIFO_DEPTH=4, ready_i=0: push 5 full words.
  - Expect valid_o held and the head stable as the first word.
  - overflow_o=1 after the 5th push.
  - Then ready_i=1: exactly 4 words drain in order.
  - frame_start clears overflow_o.
- Full with simultaneous pop: FIFO full, ready_i=1 on the cycle a 5th word completes.
  - Expect no drop and overflow_o=0.
- Reset mid-frame: assert reset_n=0 after 2 bytes with 3 words queued.
  - Expect valid_o=0 immediately.
  - After release, frame_start plus bytes 11..14 yield 11121314 only.
